// File: rtl/spi_lcd_stream.sv
// spi_lcd_stream: streams {dc, data} words from a small FIFO to an SPI LCD
// panel. The SPI link is mode 0 and sends MSB first. While it transmits it
// also captures the bits that arrive on MISO. A separate request pulses the
// LCD reset line, but only between words.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   wr_en/wr_dc/wr_data push one {dc, data} entry into the FIFO
//   lcd_rst_req         one-cycle request for an LCD hardware reset pulse
//   MISO                serial data from the LCD
//   full, overflow      FIFO full / sticky "a write was dropped"
//   busy                FSM not idle or FIFO non-empty
//   done, rx_data       end-of-word pulse and the word captured on MISO
//   MOSI, SCLK, SS, DC  SPI data, clock, chip select (low), data/command
//   RES                 LCD reset (active low)
module spi_lcd_stream #(
    parameter int DW         = 8,
    parameter int DIV        = 4,
    parameter int DEPTH      = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_dc,
    input  logic [DW-1:0] wr_data,
    input  logic          lcd_rst_req,
    input  logic          MISO,
    output logic          full,
    output logic          overflow,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rx_data,
    output logic          MOSI,
    output logic          SCLK,
    output logic          SS,
    output logic          DC,
    output logic          RES
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(((DIV > RST_CYCLES) ? DIV : RST_CYCLES) + 1);
    localparam int TW = $clog2(2 * DW);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * DW - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LCDRST, LOAD, SHIFT, GAP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_pop;

    logic [DW:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic [DW:0]       w_head;

    logic              r_pend;
    logic [CW-1:0]     r_cnt;
    logic [TW-1:0]     r_tog;
    logic              w_div_end;
    logic              w_last;
    logic [DW-1:0]     r_tx;
    logic [DW-1:0]     r_rx;
    logic [DW-1:0]     r_rx_data;
    logic              r_done;
    logic              r_sclk;
    logic              r_ss;
    logic              r_dc;
    logic              r_res;

    // FIFO: a write while full is dropped, even when a pop frees a slot in
    // the same cycle.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {wr_dc, wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full) r_overflow <= 1'b1;
        end
    end

    // FSM: next state and FIFO pop. A pending LCD reset takes priority over
    // queued words, but only at idle or at a word boundary.
    assign w_div_end = (r_cnt == DIV_LAST);
    assign w_last    = (r_tog == TOG_LAST);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend) begin
                    w_next = LCDRST;
                end else if (!w_empty) begin
                    w_next = LOAD;
                    w_pop  = 1'b1;
                end
            end
            LCDRST: if (r_cnt == RST_LAST) w_next = IDLE;
            LOAD:   w_next = SHIFT;
            SHIFT: begin
                if (w_div_end && w_last) begin
                    if (!r_pend && !w_empty) begin
                        w_next = LOAD;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = GAP;
                    end
                end
            end
            GAP:     if (w_div_end) w_next = r_pend ? LCDRST : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Serial datapath. The word's head is loaded on the edge that enters
    // LOAD, so SS, DC and the first MOSI bit are already valid in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 1'b0;
            r_cnt     <= '0;
            r_tog     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_ss      <= 1'b1;
            r_dc      <= 1'b0;
            r_res     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            // A new request wins over the clear at the end of LCDRST.
            r_pend <= lcd_rst_req || (r_pend && !(r_state == LCDRST && w_next == IDLE));

            // One counter serves as SCLK divider, GAP timer and reset timer.
            if (r_state != w_next || (r_state == SHIFT && w_div_end))
                r_cnt <= '0;
            else if (r_state != IDLE)
                r_cnt <= r_cnt + CW'(1);

            if (r_state == SHIFT && w_div_end) begin
                r_sclk <= !r_sclk;
                r_tog  <= r_tog + TW'(1);
                if (!r_sclk)
                    r_rx <= {r_rx[DW-2:0], MISO};
                else if (!w_last)
                    r_tx <= {r_tx[DW-2:0], 1'b0};
                if (w_last) begin
                    r_done    <= 1'b1;
                    r_rx_data <= r_rx;
                end
            end

            if (w_next == GAP && r_state != GAP) r_ss <= 1'b1;

            // Listed after the SHIFT update so that a back-to-back reload
            // on the final SCLK fall overrides it.
            if (w_pop) begin
                r_ss  <= 1'b0;
                r_dc  <= w_head[DW];
                r_tx  <= w_head[DW-1:0];
                r_tog <= '0;
            end

            if (w_next == LCDRST && r_state != LCDRST) r_res <= 1'b0;
            if (r_state == LCDRST && w_next == IDLE)   r_res <= 1'b1;
        end
    end

    assign full     = w_full;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign done     = r_done;
    assign rx_data  = r_rx_data;
    assign MOSI     = r_tx[DW-1];
    assign SCLK     = r_sclk;
    assign SS       = r_ss;
    assign DC       = r_dc;
    assign RES      = r_res;

endmodule

// File: doc/spi_lcd_stream.md
SPI_LCD_STREAM -- requirements
Module: spi_lcd_stream

Interface
REQ-001 Parameter DW, default 8: SPI word width in bits (DW >= 2).
REQ-002 Parameter DIV, default 4: SCLK half-period in clk cycles (DIV >= 1).
REQ-003 Parameter DEPTH, default 4: command FIFO depth in entries (power of 2, DEPTH >= 2).
REQ-004 Parameter RST_CYCLES, default 16: LCD hardware reset pulse length in clk cycles (RST_CYCLES >= 1).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  system clock; all logic is on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  push request for {wr_dc, wr_data} into the FIFO.
REQ-009 wr_dc  input  1  entry type: 0 = command, 1 = data.
REQ-010 wr_data  input  DW  word to transmit.
REQ-011 lcd_rst_req  input  1  one-cycle request to pulse the LCD reset line.
REQ-012 MISO  input  1  serial input from the LCD.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 overflow  output  1  sticky flag: a write was dropped; cleared only by rst.
REQ-015 busy  output  1  high whenever the state is not IDLE or the FIFO is non-empty.
REQ-016 done  output  1  one-cycle pulse at the end of each transmitted word.
REQ-017 rx_data  output  DW  word shifted in on MISO during the last transfer; updated with done.
REQ-018 MOSI, SCLK, SS, DC, RES  output  1 each  SPI data, SPI clock, chip select (active low), data/command select, LCD reset (active low).

Function
REQ-019 The FIFO SHALL store {dc, data} entries; a write when full is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-020 A simultaneous push and pop when the FIFO is not full SHALL leave the entry count unchanged.
REQ-021 The FSM SHALL have exactly the states IDLE, LCDRST, LOAD, SHIFT and GAP.
REQ-022 IDLE: if a reset is pending, go to LCDRST; else if the FIFO is non-empty, go to LOAD; otherwise remain in IDLE with SS=1 and SCLK=0.
REQ-023 lcd_rst_req SHALL set a pending flag in any state; the request is serviced only from IDLE or at a word boundary, never mid-word.
REQ-024 LCDRST: RES=0 for exactly RST_CYCLES cycles, then RES=1, the pending flag clears, and the FSM returns to IDLE; SS stays 1 throughout.
REQ-025 LOAD (1 cycle): pop the FIFO head; drive SS=0; DC=entry dc; MOSI=data[DW-1]; clear the divider and bit counters.
REQ-026 SHIFT: SCLK toggles every DIV cycles, giving 2*DW toggles per word (SPI mode 0, MSB first).
  - Sample MISO on each rising SCLK edge.
  - Drive MOSI with the next bit on each falling SCLK edge except the last.
REQ-027 A word SHALL take exactly 1 + 2*DW*DIV cycles from LOAD entry to the final SCLK fall.
REQ-028 done and the rx_data update SHALL occur in the cycle SCLK falls for the final time.
REQ-029 Word boundary with no reset pending:
  - If the FIFO is non-empty, go to LOAD; SS stays 0 (back-to-back burst).
  - Otherwise go to GAP.
REQ-030 Word boundary with a reset pending SHALL go to GAP, then to LCDRST.
REQ-031 GAP: SS=1 and SCLK=0 for DIV cycles, then go to IDLE.
REQ-032 DC SHALL change only in LOAD and SHALL hold its value otherwise.
REQ-033 Writes SHALL be accepted in every state, including during LCDRST.

Reset
REQ-034 On rst:
  - FSM to IDLE; FIFO emptied; pending flag cleared; overflow cleared.
  - Outputs: SS=1, SCLK=0, MOSI=0, DC=0, RES=1, done=0, busy=0, rx_data=0.
REQ-035 rst asserted mid-word SHALL abort the transfer in the same edge; the partial word is discarded and done is not pulsed.

Verification
REQ-036 DW=8, DIV=4: write {dc=0, 0xA5} -> SS low for 65 cycles, DC=0, MOSI bits 1,0,1,0,0,1,0,1 at rising edges, one done pulse, then SS=1 for 4 cycles.
REQ-037 Write {1,0x12}, {1,0x34}, {0,0x2C} on consecutive cycles -> SS stays low across all 3 words, DC=1,1,0, exactly 3 done pulses.
REQ-038 Tie MISO to the pattern 0x3C during a transfer -> rx_data=0x3C at done.
REQ-039 DEPTH=4, with the FSM stalled in LCDRST: write 5 entries -> full=1 after the 4th write, overflow=1 after the 5th, only 4 words are transmitted.
REQ-040 Pulse lcd_rst_req mid-word -> the word completes, then GAP, then RES=0 for 16 cycles; no SCLK edges occur while RES=0.
REQ-041 Assert rst on bit 3 of a transfer -> next cycle SS=1, SCLK=0, FIFO empty, no done pulse.
